aurora_reset_sequencer: RTL and testbench

- Parametrised multi-channel successor to the single-lane Aurora reset sequencer.
- Each of CHANNELS independent lanes runs its own reset sequence: assert reset_pb, then pma_init, then release.
- After release, each lane waits for a synchronised, debounced channel_up, retries on timeout up to a limit, and optionally auto-recovers when the link drops.
- Sits between board-level reset/software control and the Aurora 64B/66B cores.

---
 rtl/aurora_reset_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_aurora_reset_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_reset_sequencer.sv
// ---------------------------------------------------------------------------
// aurora_reset_sequencer
//
// Multi-channel reset sequencer for Aurora 64B/66B cores. Every lane runs its
// own copy of the bring-up sequence:
//
//    PB_LEAD  : reset_pb high, pma_init low          (PB_LEAD cycles)
//    PMA_HOLD : reset_pb high, pma_init high         (PMA_HOLD cycles)
//    PB_TAIL  : reset_pb high, pma_init low          (PB_TAIL cycles)
//    WAIT_UP  : both released, wait for channel_up to be stable for
//               UP_STABLE cycles, retry on UP_TIMEOUT
//    LINKED   : link is up; a drop restarts (AUTO_RECOVER) or fails
//    FAILED   : idle until reset_req or resetn
//
// The sequence starts on its own when resetn deasserts. reset_req is only
// honoured once the timed part of the sequence has completed.
//
// Ports (all per-lane vectors are CHANNELS wide, lane i on bit i):
//    clock         single clock domain
//    resetn        asynchronous active-low reset
//    reset_req     single-cycle request to rerun the sequence
//    channel_up    Aurora channel_up, asynchronous to clock
//    reset_pb_out  Aurora reset_pb (active high)
//    pma_init_out  Aurora pma_init (active high)
//    link_ok       lane is LINKED
//    link_failed   lane is FAILED
//    busy          lane is sequencing or waiting for the link
//    retry_count   4 bits per lane, timeouts since the last sequence start,
//                  saturating at 15 (lane i at [4*i+3:4*i])
//
// All outputs are registered.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// aurora_reset_sequencer_lane
//
// One independent lane: channel_up synchroniser, sequence FSM, shared
// dwell/timeout counter, stable counter and retry counter.
//
// Ports:
//    clock, resetn    clock and asynchronous active-low reset
//    reset_req        request to rerun the sequence
//    channel_up       raw (asynchronous) channel_up
//    reset_pb_out     registered reset_pb
//    pma_init_out     registered pma_init
//    link_ok          registered "in LINKED"
//    link_failed      registered "in FAILED"
//    busy             registered "in PB_LEAD..WAIT_UP"
//    retry_count      registered saturating timeout count
// ---------------------------------------------------------------------------
module aurora_reset_sequencer_lane #(
   parameter int PB_LEAD      = 128,
   parameter int PMA_HOLD     = 1000000,
   parameter int PB_TAIL      = 10000,
   parameter int UP_TIMEOUT   = 50000000,
   parameter int UP_STABLE    = 1000,
   parameter int MAX_RETRIES  = 3,
   parameter int AUTO_RECOVER = 1,
   parameter int SYNC_STAGES  = 2,
   parameter int CW           = 32
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       reset_req,
   input  logic       channel_up,
   output logic       reset_pb_out,
   output logic       pma_init_out,
   output logic       link_ok,
   output logic       link_failed,
   output logic       busy,
   output logic [3:0] retry_count
);

   typedef enum logic [2:0] {
      S_PB_LEAD,
      S_PMA_HOLD,
      S_PB_TAIL,
      S_WAIT_UP,
      S_LINKED,
      S_FAILED
   } state_t;

   // counter load values: entering a timed state loads (dwell - 1) so the
   // exit on counter == 0 gives a dwell of exactly the parameter value
   localparam logic [CW-1:0] LEAD_LD   = CW'(PB_LEAD - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(PMA_HOLD - 1);
   localparam logic [CW-1:0] TAIL_LD   = CW'(PB_TAIL - 1);
   localparam logic [CW-1:0] TMO_LD    = CW'(UP_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE    = CW'(UP_STABLE);
   localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRIES);
   localparam logic [CW-1:0] RC_SAT    = CW'(15);
   localparam logic [CW-1:0] ONE       = CW'(1);

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [CW-1:0]          stab, stab_nxt, stab_inc;
   logic [CW-1:0]          tries, tries_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   up_s;
   logic                   expired;
   logic                   pb_nxt;

   // ------------------------------------------------------------------
   // channel_up synchroniser
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], channel_up};
      end
   end

   assign up_s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // next-state logic
   // ------------------------------------------------------------------
   assign expired  = (cnt == '0);
   assign stab_inc = up_s ? (stab + ONE) : '0;

   always_comb begin
      state_nxt = state;
      // one counter serves every timed state; it parks at zero rather
      // than wrapping
      cnt_nxt   = expired ? cnt : (cnt - ONE);
      stab_nxt  = stab;
      tries_nxt = tries;

      case (state)
         S_PB_LEAD: begin
            if (expired) begin
               state_nxt = S_PMA_HOLD;
               cnt_nxt   = HOLD_LD;
            end
         end

         S_PMA_HOLD: begin
            if (expired) begin
               state_nxt = S_PB_TAIL;
               cnt_nxt   = TAIL_LD;
            end
         end

         S_PB_TAIL: begin
            if (expired) begin
               state_nxt = S_WAIT_UP;
               cnt_nxt   = TMO_LD;
               stab_nxt  = '0;
            end
         end

         S_WAIT_UP: begin
            stab_nxt = stab_inc;
            // priority: request, then link, then timeout
            if (reset_req) begin
               state_nxt = S_PB_LEAD;
               cnt_nxt   = LEAD_LD;
               tries_nxt = '0;
            end else if (up_s && (stab_inc >= STABLE)) begin
               state_nxt = S_LINKED;
            end else if (expired) begin
               if (tries < RETRY_MAX) begin
                  state_nxt = S_PB_LEAD;
                  cnt_nxt   = LEAD_LD;
                  tries_nxt = tries + ONE;
               end else begin
                  state_nxt = S_FAILED;
               end
            end
         end

         S_LINKED: begin
            if (reset_req) begin
               state_nxt = S_PB_LEAD;
               cnt_nxt   = LEAD_LD;
               tries_nxt = '0;
            end else if (!up_s) begin
               if (AUTO_RECOVER != 0) begin
                  // a fresh sequence: the retry budget starts again
                  state_nxt = S_PB_LEAD;
                  cnt_nxt   = LEAD_LD;
                  tries_nxt = '0;
               end else begin
                  state_nxt = S_FAILED;
               end
            end
         end

         S_FAILED: begin
            if (reset_req) begin
               state_nxt = S_PB_LEAD;
               cnt_nxt   = LEAD_LD;
               tries_nxt = '0;
            end
         end

         default: begin
            state_nxt = S_PB_LEAD;
            cnt_nxt   = LEAD_LD;
            tries_nxt = '0;
         end
      endcase
   end

   assign pb_nxt = (state_nxt == S_PB_LEAD) || (state_nxt == S_PMA_HOLD) ||
                   (state_nxt == S_PB_TAIL);

   // ------------------------------------------------------------------
   // state, counters and registered outputs
   // outputs are decoded from the next state so they line up with the
   // state register while still coming straight from flops
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= S_PB_LEAD;
         cnt          <= LEAD_LD;
         stab         <= '0;
         tries        <= '0;
         reset_pb_out <= 1'b1;
         pma_init_out <= 1'b0;
         link_ok      <= 1'b0;
         link_failed  <= 1'b0;
         busy         <= 1'b1;
         retry_count  <= 4'd0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         stab         <= stab_nxt;
         tries        <= tries_nxt;
         reset_pb_out <= pb_nxt;
         pma_init_out <= (state_nxt == S_PMA_HOLD);
         link_ok      <= (state_nxt == S_LINKED);
         link_failed  <= (state_nxt == S_FAILED);
         busy         <= pb_nxt || (state_nxt == S_WAIT_UP);
         retry_count  <= (tries_nxt > RC_SAT) ? 4'd15 : tries_nxt[3:0];
      end
   end

endmodule

// ---------------------------------------------------------------------------
// aurora_reset_sequencer (top)
//
// Replicates the lane CHANNELS times; lanes share only clock and resetn.
// ---------------------------------------------------------------------------
module aurora_reset_sequencer #(
   parameter int CHANNELS     = 1,
   parameter int PB_LEAD      = 128,
   parameter int PMA_HOLD     = 1000000,
   parameter int PB_TAIL      = 10000,
   parameter int UP_TIMEOUT   = 50000000,
   parameter int UP_STABLE    = 1000,
   parameter int MAX_RETRIES  = 3,
   parameter int AUTO_RECOVER = 1,
   parameter int SYNC_STAGES  = 2,
   parameter int CW           = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [CHANNELS-1:0]   reset_req,
   input  logic [CHANNELS-1:0]   channel_up,
   output logic [CHANNELS-1:0]   reset_pb_out,
   output logic [CHANNELS-1:0]   pma_init_out,
   output logic [CHANNELS-1:0]   link_ok,
   output logic [CHANNELS-1:0]   link_failed,
   output logic [CHANNELS-1:0]   busy,
   output logic [CHANNELS*4-1:0] retry_count
);

   logic [CHANNELS-1:0][3:0] rc_lane;

   assign retry_count = rc_lane;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      aurora_reset_sequencer_lane #(
         .PB_LEAD      (PB_LEAD),
         .PMA_HOLD     (PMA_HOLD),
         .PB_TAIL      (PB_TAIL),
         .UP_TIMEOUT   (UP_TIMEOUT),
         .UP_STABLE    (UP_STABLE),
         .MAX_RETRIES  (MAX_RETRIES),
         .AUTO_RECOVER (AUTO_RECOVER),
         .SYNC_STAGES  (SYNC_STAGES),
         .CW           (CW)
      ) u_lane (
         .clock        (clock),
         .resetn       (resetn),
         .reset_req    (reset_req[g]),
         .channel_up   (channel_up[g]),
         .reset_pb_out (reset_pb_out[g]),
         .pma_init_out (pma_init_out[g]),
         .link_ok      (link_ok[g]),
         .link_failed  (link_failed[g]),
         .busy         (busy[g]),
         .retry_count  (rc_lane[g])
      );
   end

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aurora_reset_sequencer
//
// Scoreboard bench. A reference model (elapsed-cycle arithmetic per lane)
// advances on every clock edge and pushes the outputs it expects into a
// queue; a monitor on the falling edge pops one entry per cycle and compares
// it with the DUT. Directed phases cover power-up, link, drop/recover,
// glitch, retry/fail and request/async-reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_aurora_reset_sequencer;

   localparam int CH          = 2;
   localparam int PB_LEAD     = 4;
   localparam int PMA_HOLD    = 8;
   localparam int PB_TAIL     = 3;
   localparam int UP_TIMEOUT  = 20;
   localparam int UP_STABLE   = 5;
   localparam int MAX_RETRIES = 2;
   localparam int SYNC        = 2;
   localparam int SEQ_LEN     = PB_LEAD + PMA_HOLD + PB_TAIL;

   localparam int M_SEQ    = 0;
   localparam int M_LINKED = 1;
   localparam int M_FAILED = 2;

   logic            clock = 1'b0;
   logic            resetn = 1'b1;
   logic [CH-1:0]   reset_req = '0;
   logic [CH-1:0]   channel_up = '0;
   logic [CH-1:0]   reset_pb_out, pma_init_out, link_ok, link_failed, busy;
   logic [CH*4-1:0] retry_count;

   typedef struct packed {
      logic [CH-1:0]   pb;
      logic [CH-1:0]   pma;
      logic [CH-1:0]   ok;
      logic [CH-1:0]   failed;
      logic [CH-1:0]   busy;
      logic [CH*4-1:0] rc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // model state: where each lane is, measured in cycles since its
   // sequence began, plus the link-stable run length and retries
   int   age[CH];
   int   mode[CH];
   int   run[CH];
   int   retries[CH];
   bit   hist[CH][SYNC];
   bit [CH-1:0] tgt = '0;

   aurora_reset_sequencer #(
      .CHANNELS     (CH),
      .PB_LEAD      (PB_LEAD),
      .PMA_HOLD     (PMA_HOLD),
      .PB_TAIL      (PB_TAIL),
      .UP_TIMEOUT   (UP_TIMEOUT),
      .UP_STABLE    (UP_STABLE),
      .MAX_RETRIES  (MAX_RETRIES),
      .AUTO_RECOVER (1),
      .SYNC_STAGES  (SYNC),
      .CW           (32)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .reset_req    (reset_req),
      .channel_up   (channel_up),
      .reset_pb_out (reset_pb_out),
      .pma_init_out (pma_init_out),
      .link_ok      (link_ok),
      .link_failed  (link_failed),
      .busy         (busy),
      .retry_count  (retry_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // ------------------------------------------------------------------
   // reference model
   // ------------------------------------------------------------------
   task automatic model_restart(input int i);
      mode[i]    = M_SEQ;
      age[i]     = 0;
      retries[i] = 0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < CH; i++) begin
         model_restart(i);
         run[i] = 0;
         for (int k = 0; k < SYNC; k++) hist[i][k] = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input bit ch, input bit req);
      bit up;
      int nrun;
      up = hist[i][SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = ch;
      case (mode[i])
         M_SEQ: begin
            if (age[i] < SEQ_LEN) begin
               age[i]++;
               if (age[i] == SEQ_LEN) run[i] = 0;
            end else begin
               nrun = up ? run[i] + 1 : 0;
               if (req) model_restart(i);
               else if (nrun >= UP_STABLE) mode[i] = M_LINKED;
               else if (age[i] - SEQ_LEN == UP_TIMEOUT - 1) begin
                  if (retries[i] < MAX_RETRIES) begin
                     retries[i]++;
                     age[i] = 0;
                  end else begin
                     mode[i] = M_FAILED;
                  end
               end else begin
                  age[i]++;
                  run[i] = nrun;
               end
            end
         end
         M_LINKED: if (req || !up) model_restart(i);
         default:  if (req) model_restart(i);
      endcase
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e = '0;
      for (int i = 0; i < CH; i++) begin
         case (mode[i])
            M_SEQ: begin
               e.pb[i]   = (age[i] < SEQ_LEN);
               e.pma[i]  = (age[i] >= PB_LEAD) && (age[i] < PB_LEAD + PMA_HOLD);
               e.busy[i] = 1'b1;
            end
            M_LINKED: e.ok[i] = 1'b1;
            default:  e.failed[i] = 1'b1;
         endcase
         e.rc[i*4 +: 4] = 4'((retries[i] > 15) ? 15 : retries[i]);
      end
      return e;
   endfunction

   // one expected entry per cycle; an asynchronous reset replaces the
   // entry of the cycle it lands in
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         model_clear();
         if (exp_q.size() > 0) void'(exp_q.pop_back());
         exp_q.push_back(model_out());
      end else begin
         for (int i = 0; i < CH; i++) model_step(i, channel_up[i], reset_req[i]);
         exp_q.push_back(model_out());
      end
   end

   // ------------------------------------------------------------------
   // monitor
   // ------------------------------------------------------------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("reset_pb_out", 8'(reset_pb_out), 8'(mon_e.pb));
         chk("pma_init_out", 8'(pma_init_out), 8'(mon_e.pma));
         chk("link_ok",      8'(link_ok),      8'(mon_e.ok));
         chk("link_failed",  8'(link_failed),  8'(mon_e.failed));
         chk("busy",         8'(busy),         8'(mon_e.busy));
         chk("retry_count",  8'(retry_count),  8'(mon_e.rc));
      end
   end

   // ------------------------------------------------------------------
   // stimulus
   // ------------------------------------------------------------------
   task automatic rand_phase(input int n);
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 11) == 0) tgt[i] = ~tgt[i];
            channel_up[i] = ($urandom_range(0, 29) == 0) ? ~tgt[i] : tgt[i];
            reset_req[i]  = ($urandom_range(0, 59) == 0);
         end
         @(negedge clock);
      end
      reset_req = '0;
   endtask

   task automatic async_reset_pulse();
      @(posedge clock);
      #2 resetn = 1'b0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
   endtask

   bit pat[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      #1 resetn = 1'b0;
      repeat (3) @(negedge clock);

      // power-up, channel_up low
      resetn = 1'b1;
      repeat (17) @(negedge clock);

      // link: raise channel_up two cycles into WAIT_UP
      channel_up = 2'b11;
      repeat (25) @(negedge clock);

      // drop/recover lane 0 only
      channel_up[0] = 1'b0;
      repeat (20) @(negedge clock);
      channel_up[0] = 1'b1;
      repeat (25) @(negedge clock);

      // glitch on lane 1: rerun its sequence, then 3 high, 1 low, then high
      reset_req     = 2'b10;
      channel_up[1] = 1'b0;
      @(negedge clock);
      reset_req = '0;
      repeat (16) @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         channel_up[1] = pat[k];
         @(negedge clock);
      end
      channel_up[1] = 1'b1;
      repeat (20) @(negedge clock);

      // retry/fail: link never comes up
      channel_up = 2'b00;
      reset_req  = 2'b11;
      @(negedge clock);
      reset_req = '0;
      repeat (120) @(negedge clock);

      // request out of FAILED, ignored request in PMA_HOLD, then an
      // asynchronous reset in the middle of PMA_HOLD
      reset_req = 2'b11;
      @(negedge clock);
      reset_req = '0;
      repeat (5) @(negedge clock);
      reset_req = 2'b01;
      @(negedge clock);
      reset_req = '0;
      async_reset_pulse();
      channel_up = 2'b11;
      repeat (40) @(negedge clock);

      // randomized traffic with an asynchronous reset in between
      rand_phase(300);
      async_reset_pulse();
      rand_phase(300);
      repeat (3) @(negedge clock);

      checks++;
      if (checks < 1000) begin
         errors++;
         $display("FAIL check_count: got %0d checks, want at least 1000", checks);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
